// File: rtl/sift_pkg.sv
// Shared types and constants for the keypoint stream path: coordinate word layout,
// buffer entry format and transmitter states.
package sift_pkg;

    localparam int unsigned KEY_COORD_W = 16;
    localparam logic [KEY_COORD_W-1:0] KEY_TRAILER_TAG = 16'hFFFF;

    typedef struct packed {
        logic [KEY_COORD_W-1:0] row;
        logic [KEY_COORD_W-1:0] col;
    } key_word_t;

    typedef struct packed {
        logic      last;
        key_word_t word;
    } key_entry_t;

    typedef enum logic {
        ST_RUN,
        ST_TRAIL
    } key_tx_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/key_axis_tx_if.sv
// AXI4-Stream style keypoint channel between the keypoint buffer and its consumer.
interface key_axis_tx_if;

    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/key_fifo.sv
// Keypoint output buffer: FWFT with a registered head, two write ports so a keypoint
// and the frame trailer can be queued on the same edge (port A is written first).
module key_fifo
    import sift_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
)(
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          push_a_i,
    input  key_entry_t                    data_a_i,
    input  logic                          push_b_i,
    input  key_entry_t                    data_b_i,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    key_axis_tx_if.master                 m_axis
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;

    key_entry_t      mem_q [FIFO_DEPTH];
    ptr_t            wr_ptr_q, wr_ptr_d;
    ptr_t            rd_ptr_q, rd_ptr_d;
    ptr_t            wr_ptr_b;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   count_left;
    key_entry_t      head_q, head_d;
    logic            head_vld_q, head_vld_d;
    logic            pop;

    assign pop = head_vld_q & m_axis.tready;

    always_comb begin
        rd_ptr_d   = rd_ptr_q + ptr_t'(pop);
        wr_ptr_b   = wr_ptr_q + ptr_t'(push_a_i);
        wr_ptr_d   = wr_ptr_b + ptr_t'(push_b_i);
        count_d    = count_q + CW'(push_a_i) + CW'(push_b_i) - CW'(pop);
        // Head is refilled only from entries already stored before this edge.
        count_left = count_q - CW'(pop);
        head_vld_d = (count_left != '0);
        head_d     = head_vld_d ? mem_q[rd_ptr_d] : '0;
    end

    always_ff @(posedge clk_i) begin
        if (push_a_i) mem_q[wr_ptr_q] <= data_a_i;
        if (push_b_i) mem_q[wr_ptr_b] <= data_b_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
        end
    end

    assign count_o       = count_q;
    assign m_axis.tvalid = head_vld_q;
    assign m_axis.tdata  = head_q.word;
    assign m_axis.tlast  = head_q.last;

endmodule

// File: rtl/key_axis_tx.sv
// Turns the extreme-detector raster mark stream into {row,col} keypoint words plus a
// per-frame trailer carrying the accepted-keypoint count.
module key_axis_tx
    import sift_pkg::*;
#(
    parameter int unsigned IMAGE_COLUMN = 512,
    parameter int unsigned IMAGE_ROW    = 512,
    parameter int unsigned FIFO_DEPTH   = 16
)(
    input  logic        axi_clk,
    input  logic        axi_rst,
    input  logic        key_valid,
    input  logic        key_mark,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        frame_done,
    output logic        overflow,
    output logic [15:0] drop_cnt
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0]   COL_LAST  = 16'(IMAGE_COLUMN - 1);
    localparam logic [15:0]   ROW_LAST  = 16'(IMAGE_ROW - 1);
    localparam logic [CW-1:0] KP_LIMIT  = CW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    key_tx_state_e state_q, state_d;
    logic [15:0]   col_q, col_d;
    logic [15:0]   row_q, row_d;
    logic [15:0]   kp_cnt_q, kp_cnt_d;
    logic [15:0]   kp_cnt_inc;
    logic [15:0]   drop_q, drop_d;
    logic          ovf_q, ovf_d;
    logic          done_q;
    logic          kp_push, tr_push, last_px;
    logic [CW-1:0] fifo_cnt;
    key_entry_t    kp_entry, tr_entry;

    key_axis_tx_if axis_if ();

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        drop_d   = drop_q;
        ovf_d    = ovf_q;
        kp_push  = 1'b0;
        tr_push  = 1'b0;
        last_px  = key_valid && (col_q == COL_LAST) && (row_q == ROW_LAST);

        // The last buffer slot is held back so a trailer can always follow a keypoint.
        if (key_valid && key_mark) begin
            if (state_q == ST_RUN && fifo_cnt < KP_LIMIT) begin
                kp_push = 1'b1;
            end else begin
                drop_d = sat_inc16(drop_q);
                ovf_d  = 1'b1;
            end
        end

        kp_cnt_inc = kp_push ? sat_inc16(kp_cnt_q) : kp_cnt_q;
        kp_cnt_d   = kp_cnt_inc;

        case (state_q)
            ST_RUN: begin
                if (last_px) begin
                    if ((fifo_cnt + CW'(kp_push)) < FIFO_FULL) tr_push = 1'b1;
                    else                                       state_d = ST_TRAIL;
                end
            end
            ST_TRAIL: begin
                if (fifo_cnt < FIFO_FULL) begin
                    tr_push = 1'b1;
                    state_d = ST_RUN;
                end
            end
        endcase

        if (tr_push) kp_cnt_d = '0;

        if (key_valid) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 16'd1;
            end else begin
                col_d = col_q + 16'd1;
            end
        end
    end

    assign kp_entry = key_entry_t'({1'b0, row_q, col_q});
    assign tr_entry = key_entry_t'({1'b1, KEY_TRAILER_TAG, kp_cnt_inc});

    always_ff @(posedge axi_clk or negedge axi_rst) begin
        if (!axi_rst) begin
            state_q  <= ST_RUN;
            col_q    <= '0;
            row_q    <= '0;
            kp_cnt_q <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            kp_cnt_q <= kp_cnt_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            done_q   <= tr_push;
        end
    end

    key_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (axi_clk),
        .rst_ni   (axi_rst),
        .push_a_i (kp_push),
        .data_a_i (kp_entry),
        .push_b_i (tr_push),
        .data_b_i (tr_entry),
        .count_o  (fifo_cnt),
        .m_axis   (axis_if.master)
    );

    assign axis_if.tready = m_axis_tready;
    assign m_axis_tdata   = axis_if.tdata;
    assign m_axis_tvalid  = axis_if.tvalid;
    assign m_axis_tlast   = axis_if.tlast;
    assign frame_done     = done_q;
    assign overflow       = ovf_q;
    assign drop_cnt       = drop_q;

endmodule

// File: tb/tb_key_axis_tx.sv
// Bench for key_axis_tx on an 8x4 image with a 16-entry buffer: table-checked frames,
// corner-case sequences and a randomized run against a pixel-index/queue reference model.
module tb_key_axis_tx;
    import sift_pkg::*;

    localparam int unsigned COLS  = 8;
    localparam int unsigned ROWS  = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned NPIX  = COLS * ROWS;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        kv    = 1'b0;
    logic        km    = 1'b0;
    logic        frame_done;
    logic        overflow;
    logic [15:0] drop_cnt;

    key_axis_tx_if axs ();

    always #5 clk = ~clk;

    key_axis_tx #(
        .IMAGE_COLUMN (COLS),
        .IMAGE_ROW    (ROWS),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .axi_clk       (clk),
        .axi_rst       (rst_n),
        .key_valid     (kv),
        .key_mark      (km),
        .m_axis_tdata  (axs.tdata),
        .m_axis_tvalid (axs.tvalid),
        .m_axis_tready (axs.tready),
        .m_axis_tlast  (axs.tlast),
        .frame_done    (frame_done),
        .overflow      (overflow),
        .drop_cnt      (drop_cnt)
    );

    typedef struct {
        int          row;
        int          col;
        logic [31:0] data;
        logic        last;
    } vec_t;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [32:0] exp_q [$];
    logic [32:0] got_q [$];
    int unsigned m_pix, m_kp, m_drop, n_done;
    bit          m_ovf, m_pend, m_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        got_q.delete();
        m_pix  = 0;
        m_kp   = 0;
        m_drop = 0;
        m_ovf  = 0;
        m_pend = 0;
        m_done = 0;
        n_done = 0;
    endtask

    task automatic model_step(input logic v, input logic m, input logic r,
                              input logic vld, input logic [31:0] data, input logic last);
        bit          pend0, trailer, pop;
        int unsigned occ0, pushes;
        pend0   = m_pend;
        occ0    = exp_q.size();
        pushes  = 0;
        trailer = 0;
        pop     = vld && r;
        if (vld && occ0 == 0) chk("spurious_valid", 64'(vld), 64'd0);
        if (pop) begin
            got_q.push_back({last, data});
            if (exp_q.size() > 0) begin
                chk("stream_word", {31'd0, last, data}, {31'd0, exp_q[0]});
                exp_q.delete(0);
            end
        end
        if (v && m) begin
            if (!pend0 && occ0 < DEPTH - 1) begin
                exp_q.push_back({1'b0, 16'(m_pix / COLS), 16'(m_pix % COLS)});
                pushes = 1;
                if (m_kp < 65535) m_kp++;
            end else begin
                if (m_drop < 65535) m_drop++;
                m_ovf = 1;
            end
        end
        if (pend0) begin
            if (occ0 < DEPTH) begin
                trailer = 1;
                m_pend  = 0;
            end
        end else if (v && m_pix == NPIX - 1) begin
            if (occ0 + pushes < DEPTH) trailer = 1;
            else                       m_pend  = 1;
        end
        if (trailer) begin
            exp_q.push_back({1'b1, 16'hFFFF, 16'(m_kp)});
            m_kp = 0;
        end
        if (v) m_pix = (m_pix + 1) % NPIX;
        m_done = trailer;
    endtask

    // One clock: drive at the falling edge, model the coming rising edge, check at the next fall.
    task automatic cycle(input logic v, input logic m, input logic r);
        logic        pvld, plast;
        logic [31:0] pdata;
        kv         = v;
        km         = m;
        axs.tready = r;
        pvld       = axs.tvalid;
        pdata      = axs.tdata;
        plast      = axs.tlast;
        model_step(v, m, r, pvld, pdata, plast);
        @(negedge clk);
        if (frame_done) n_done++;
        chk("frame_done", 64'(frame_done), 64'(m_done));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        if (pvld && !r) begin
            chk("hold_valid", 64'(axs.tvalid), 64'd1);
            chk("hold_data", {31'd0, axs.tlast, axs.tdata}, {31'd0, plast, pdata});
        end
    endtask

    task automatic do_reset();
        kv         = 1'b0;
        km         = 1'b0;
        axs.tready = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic drain();
        int unsigned budget;
        budget = 0;
        while ((exp_q.size() != 0 || axs.tvalid) && budget < 200) begin
            cycle(1'b0, 1'b0, 1'b1);
            budget++;
        end
        chk("drain_timeout", 64'(budget < 200), 64'd1);
    endtask

    vec_t tbl [4];
    bit   mk  [NPIX];

    initial begin
        axs.tready = 1'b0;
        tbl[0] = '{0, 3, 32'h0000_0003, 1'b0};
        tbl[1] = '{2, 7, 32'h0002_0007, 1'b0};
        tbl[2] = '{3, 7, 32'h0003_0007, 1'b0};
        tbl[3] = '{-1, -1, 32'hFFFF_0003, 1'b1};
        for (int p = 0; p < NPIX; p++) mk[p] = 0;
        for (int i = 0; i < 4; i++)
            if (tbl[i].row >= 0) mk[tbl[i].row * COLS + tbl[i].col] = 1;

        @(negedge clk);
        do_reset();
        chk("rst_tvalid", 64'(axs.tvalid), 64'd0);
        chk("rst_tdata", 64'(axs.tdata), 64'd0);
        chk("rst_tlast", 64'(axs.tlast), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);

        // Basic frame with a free-running consumer.
        for (int p = 0; p < NPIX; p++) cycle(1'b1, mk[p], 1'b1);
        drain();
        chk("t35_count", 64'(got_q.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < got_q.size())
                chk("t35_word", {31'd0, got_q[i]}, {31'd0, tbl[i].last, tbl[i].data});
        chk("t35_done_pulses", 64'(n_done), 64'd1);

        // Same frame with key_valid toggling and consumer stalls.
        do_reset();
        for (int p = 0; p < NPIX; p++) begin
            cycle(1'b1, mk[p], (p % 3) != 0);
            cycle(1'b0, 1'b1, (p % 4) == 1);
        end
        drain();
        chk("t38_count", 64'(got_q.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < got_q.size())
                chk("t38_word", {31'd0, got_q[i]}, {31'd0, tbl[i].last, tbl[i].data});

        // Consumer stalled for a whole fully-marked frame.
        do_reset();
        for (int p = 0; p < NPIX; p++) cycle(1'b1, 1'b1, 1'b0);
        chk("t36_drop_cnt", 64'(drop_cnt), 64'd17);
        chk("t36_overflow", 64'(overflow), 64'd1);
        chk("t36_done_pulses", 64'(n_done), 64'd1);
        drain();
        chk("t36_count", 64'(got_q.size()), 64'd16);
        if (got_q.size() == 16) begin
            chk("t36_kp15", {31'd0, got_q[14]}, {31'd0, 33'h0_0001_0006});
            chk("t36_trailer", {31'd0, got_q[15]}, {31'd0, 33'h1_FFFF_000F});
        end

        // Buffer full at frame end: trailer waits until one word is popped.
        do_reset();
        for (int p = 0; p < NPIX; p++) cycle(1'b1, 1'b1, 1'b0);
        n_done = 0;
        for (int p = 0; p < NPIX; p++) cycle(1'b1, 1'b0, 1'b0);
        chk("t37_no_done_full", 64'(n_done), 64'd0);
        for (int p = 0; p < 3; p++) cycle(1'b1, 1'b1, 1'b0);
        chk("t37_drop_cnt", 64'(drop_cnt), 64'd20);
        cycle(1'b0, 1'b0, 1'b1);
        chk("t37_no_done_pop", 64'(frame_done), 64'd0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("t37_done", 64'(frame_done), 64'd1);
        drain();
        chk("t37_count", 64'(got_q.size()), 64'd17);
        if (got_q.size() == 17)
            chk("t37_trailer2", {31'd0, got_q[16]}, {31'd0, 33'h1_FFFF_0000});

        // Reset mid-frame with queued entries, then head latency and fresh frame.
        do_reset();
        for (int p = 0; p < 12; p++) cycle(1'b1, (p == 1 || p == 2), 1'b0);
        chk("t39_pre_valid", 64'(axs.tvalid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t39_rst_valid", 64'(axs.tvalid), 64'd0);
        chk("t39_rst_tdata", 64'(axs.tdata), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(1'b1, 1'b1, 1'b0);
        chk("lat_push_edge", 64'(axs.tvalid), 64'd0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("lat_next_edge", 64'(axs.tvalid), 64'd1);
        chk("lat_tdata", 64'(axs.tdata), 64'd0);
        for (int p = 2; p < NPIX; p++) cycle(1'b1, 1'b0, 1'b0);
        drain();
        chk("t39_count", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) begin
            chk("t39_first", {31'd0, got_q[0]}, {31'd0, 33'h0_0000_0000});
            chk("t39_trailer", {31'd0, got_q[1]}, {31'd0, 33'h1_FFFF_0001});
        end

        // Randomized traffic, alternating between eager and starved consumer phases.
        do_reset();
        for (int i = 0; i < 1200; i++)
            cycle($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 40,
                  $urandom_range(0, 99) < ((((i / 200) % 2) == 1) ? 15 : 70));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
